mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 57 +++++
 rtl/mem_ctrl_stat.sv | 39 +++
 rtl/mem_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory controller: bus widths,
// ownership FSM encoding, response owner tags and the FSM transition rule.
package mem_ctrl_pkg;

  localparam int RamAddrBus = 17;  // RAM byte address width
  localparam int MemDataBus = 8;   // byte data width
  localparam int StatW      = 32;  // statistics counter width
  localparam int NumStat    = 3;   // reads, writes, priority conflicts

  // Ownership FSM: records who holds the port for the next grant.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_MEM = 2'd1,
    ST_OWN_IF  = 2'd2
  } state_e;

  // Owner tag carried alongside an in-flight read response.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  // Registered response descriptor: a read is in flight and who gets it.
  typedef struct packed {
    logic   vld;
    owner_e own;
  } rsp_tag_t;

  // Every grant is a single byte, so every cycle is a byte boundary and a
  // MEM request preempts IF ownership on the very next grant.
  function automatic state_e next_state(input state_e s,
                                        input logic   mem_req,
                                        input logic   if_req);
    state_e n;
    n = s;
    case (s)
      ST_IDLE: begin
        if (mem_req)     n = ST_OWN_MEM;
        else if (if_req) n = ST_OWN_IF;
      end
      ST_OWN_MEM: begin
        if (mem_req)     n = ST_OWN_MEM;
        else if (if_req) n = ST_OWN_IF;
        else             n = ST_IDLE;
      end
      ST_OWN_IF: begin
        if (mem_req)     n = ST_OWN_MEM;
        else if (if_req) n = ST_OWN_IF;
        else             n = ST_IDLE;
      end
      default:           n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_stat.sv
// Statistics counters for mem_ctrl (read grants, write grants, cycles where
// IF stalled behind MEM). Present only when MEM_CTRL_STAT_EN is defined.
`ifdef MEM_CTRL_STAT_EN
module mem_ctrl_stat
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_evt_i,
  input  logic             wr_evt_i,
  input  logic             conf_evt_i,
  output logic [StatW-1:0] stat_rd_o,
  output logic [StatW-1:0] stat_wr_o,
  output logic [StatW-1:0] stat_conf_o
);

  logic [NumStat-1:0]            evt;
  logic [NumStat-1:0][StatW-1:0] cnt_q, cnt_d;

  // Increment each counter on its event; wraps naturally at 2^32.
  always_comb begin
    evt = {conf_evt_i, wr_evt_i, rd_evt_i};
    for (int i = 0; i < NumStat; i++) begin
      cnt_d[i] = cnt_q[i] + StatW'(evt[i]);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stat_rd_o   = cnt_q[0];
  assign stat_wr_o   = cnt_q[1];
  assign stat_conf_o = cnt_q[2];

endmodule
`endif

// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter between an instruction-fetch port and a load/store
// port. One byte granted per ready cycle, MEM over IF; reads return one
// cycle later, steered by a registered owner tag.
// Optional: define MEM_CTRL_STAT_EN to add the stat_*_o counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  mem_req_i,
  input  logic                  mem_write_enable_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [MemDataBus-1:0] mem_data_i,
  output logic [MemDataBus-1:0] if_data_o,
  output logic [MemDataBus-1:0] mem_data_o,
  output logic                  if_valid_o,
  output logic                  mem_valid_o,
  output logic                  if_stall_o,
  output logic                  mem_stall_o,
  output logic [RamAddrBus-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [MemDataBus-1:0] ram_dout_o,
  input  logic [MemDataBus-1:0] ram_din_i
`ifdef MEM_CTRL_STAT_EN
  ,
  output logic [StatW-1:0]      stat_rd_o,
  output logic [StatW-1:0]      stat_wr_o,
  output logic [StatW-1:0]      stat_conf_o
`endif
);

  logic                  run;
  logic                  gnt_mem, gnt_if, gnt_rd;
  state_e                state_q, state_d;
  rsp_tag_t              rsp_q, rsp_d;
  logic [RamAddrBus-1:0] addr_q, addr_d;
  logic [MemDataBus-1:0] if_hold_q, if_hold_d;
  logic [MemDataBus-1:0] mem_hold_q, mem_hold_d;
  logic                  unused_addr_hi;

  // RAM is 128 KiB; the upper address bits are deliberately ignored.
  assign unused_addr_hi = ^{if_addr_i[31:RamAddrBus], mem_addr_i[31:RamAddrBus]};

  // Grant: at most one byte per ready cycle, MEM wins ties. Reset also
  // blocks grants so the RAM side reads as idle while rst_n is low.
  always_comb begin
    run     = rdy & rst_n;
    gnt_mem = run & mem_req_i;
    gnt_if  = run & if_req_i & ~mem_req_i;
    gnt_rd  = gnt_if | (gnt_mem & ~mem_write_enable_i);
  end

  // Ownership FSM next state; frozen while not ready.
  always_comb begin
    state_d = state_q;
    if (run) state_d = next_state(state_q, mem_req_i, if_req_i);
  end

  // RAM side driven straight from the granted requester; the address
  // holds its last value when nothing is granted.
  always_comb begin
    addr_d = addr_q;
    if (gnt_mem)     addr_d = mem_addr_i[RamAddrBus-1:0];
    else if (gnt_if) addr_d = if_addr_i[RamAddrBus-1:0];
    ram_addr_o = addr_d;
    ram_wr_o   = gnt_mem & mem_write_enable_i;
    ram_dout_o = rst_n ? mem_data_i : '0;
  end

  // Tag the read issued this cycle so its return byte is routed by who was
  // granted, not by whoever is requesting when the data comes back.
  always_comb begin
    rsp_d.vld = gnt_rd;
    rsp_d.own = gnt_mem ? OWN_MEM : (gnt_if ? OWN_IF : OWN_NONE);
  end

  // Return path and stalls; data outputs hold the last returned byte.
  always_comb begin
    if_valid_o  = rsp_q.vld & (rsp_q.own == OWN_IF);
    mem_valid_o = rsp_q.vld & (rsp_q.own == OWN_MEM);
    if_data_o   = if_valid_o  ? ram_din_i : if_hold_q;
    mem_data_o  = mem_valid_o ? ram_din_i : mem_hold_q;
    if_hold_d   = if_data_o;
    mem_hold_d  = mem_data_o;
    if_stall_o  = rst_n & if_req_i  & ~gnt_if;
    mem_stall_o = rst_n & mem_req_i & ~gnt_mem;
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rsp_q      <= '{vld: 1'b0, own: OWN_NONE};
      addr_q     <= '0;
      if_hold_q  <= '0;
      mem_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      addr_q     <= addr_d;
      if_hold_q  <= if_hold_d;
      mem_hold_q <= mem_hold_d;
    end
  end

`ifdef MEM_CTRL_STAT_EN
  mem_ctrl_stat u_stat (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_evt_i    (gnt_rd),
    .wr_evt_i    (gnt_mem & mem_write_enable_i),
    .conf_evt_i  (gnt_mem & if_req_i),
    .stat_rd_o   (stat_rd_o),
    .stat_wr_o   (stat_wr_o),
    .stat_conf_o (stat_conf_o)
  );
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model and a behavioural RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        mem_req_i;
  logic        mem_write_enable_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_data_i;
  logic [7:0]  if_data_o, mem_data_o;
  logic        if_valid_o, mem_valid_o, if_stall_o, mem_stall_o;
  logic [16:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
`ifdef MEM_CTRL_STAT_EN
  logic [31:0] stat_rd_o, stat_wr_o, stat_conf_o;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .mem_req_i(mem_req_i), .mem_write_enable_i(mem_write_enable_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .if_data_o(if_data_o), .mem_data_o(mem_data_o),
    .if_valid_o(if_valid_o), .mem_valid_o(mem_valid_o),
    .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
    .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
`ifdef MEM_CTRL_STAT_EN
    , .stat_rd_o(stat_rd_o), .stat_wr_o(stat_wr_o), .stat_conf_o(stat_conf_o)
`endif
  );

  // Power-up RAM contents (0x00100 preloaded with 0xA5).
  function automatic logic [7:0] pat(input logic [16:0] a);
    logic [7:0] m;
    m = a[7:0] * 8'd7;
    if (a == 17'h00100) return 8'hA5;
    return m ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h3C;
  endfunction

  // Behavioural synchronous RAM: read data one cycle after the address.
  logic [7:0] ram_arr [int];
  logic [7:0] ram_q = 8'h00;
  int         ram_k;
  always @(posedge clk) begin
    ram_k = int'(ram_addr_o);
    ram_q <= ram_arr.exists(ram_k) ? ram_arr[ram_k] : pat(ram_addr_o);
    if (ram_wr_o) ram_arr[ram_k] = ram_dout_o;
  end
  assign ram_din_i = ram_q;

  // ---------------- reference model (transaction level) ----------------
  logic [7:0]  ref_mem [int];
  logic [16:0] m_last_addr;
  logic        m_pend_if, m_pend_mem;
  logic [7:0]  m_pend_data, m_if_hold, m_mem_hold;
  logic [31:0] m_st_rd, m_st_wr, m_st_conf;
  // expected values for the current cycle
  logic        e_gi, e_gm, e_wr, e_if_stall, e_mem_stall, e_if_valid, e_mem_valid;
  logic [16:0] e_addr;
  logic [7:0]  e_dout, e_if_data, e_mem_data;

  function automatic logic [7:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  task automatic model_reset();
    m_last_addr = '0; m_pend_if = 0; m_pend_mem = 0; m_pend_data = '0;
    m_if_hold = '0; m_mem_hold = '0; m_st_rd = '0; m_st_wr = '0; m_st_conf = '0;
  endtask

  // What this cycle should look like, from the arbitration rules.
  task automatic model_eval();
    e_gm        = rdy & mem_req_i;
    e_gi        = rdy & if_req_i & ~mem_req_i;
    e_addr      = e_gm ? mem_addr_i[16:0] : (e_gi ? if_addr_i[16:0] : m_last_addr);
    e_wr        = e_gm & mem_write_enable_i;
    e_dout      = mem_data_i;
    e_if_stall  = if_req_i & ~e_gi;
    e_mem_stall = mem_req_i & ~e_gm;
    e_if_valid  = m_pend_if;
    e_mem_valid = m_pend_mem;
    e_if_data   = m_pend_if  ? m_pend_data : m_if_hold;
    e_mem_data  = m_pend_mem ? m_pend_data : m_mem_hold;
  endtask

  // Advance the model past the clock edge.
  task automatic model_commit();
    if (e_if_valid)  m_if_hold  = m_pend_data;
    if (e_mem_valid) m_mem_hold = m_pend_data;
    m_pend_if  = e_gi;
    m_pend_mem = e_gm & ~mem_write_enable_i;
    if (e_gi || (e_gm && !mem_write_enable_i)) begin
      m_pend_data = ref_rd(e_addr);
      m_st_rd++;
    end
    if (e_wr) begin
      ref_mem[int'(e_addr)] = mem_data_i;
      m_st_wr++;
    end
    if (e_gm && if_req_i) m_st_conf++;
    m_last_addr = e_addr;
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic mr, input logic we, input logic [31:0] ma,
                       input logic [7:0] md);
    rdy = r; if_req_i = ir; if_addr_i = ia;
    mem_req_i = mr; mem_write_enable_i = we; mem_addr_i = ma; mem_data_i = md;
  endtask

  task automatic half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic fin();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 32'h0000_0123, 1, 1, 32'h0000_0456, 8'h77);
    #2;
    checks++; if (ram_addr_o !== 17'h0) begin errs++; $display("FAIL rst_addr got=%h exp=0", ram_addr_o); end
    checks++; if ({ram_wr_o, if_stall_o, mem_stall_o, if_valid_o, mem_valid_o} !== 5'b0) begin errs++; $display("FAIL rst_ctl got=%b exp=00000", {ram_wr_o, if_stall_o, mem_stall_o, if_valid_o, mem_valid_o}); end
    checks++; if ({if_data_o, mem_data_o} !== 16'h0) begin errs++; $display("FAIL rst_data got=%h exp=0", {if_data_o, mem_data_o}); end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_if_read();
    drive(1, 1, 32'h0000_0100, 0, 0, 0, 0); half();
    checks++; if (ram_addr_o !== 17'h00100) begin errs++; $display("FAIL if_rd_addr got=%h exp=00100", ram_addr_o); end
    checks++; if ({ram_wr_o, if_stall_o} !== 2'b00) begin errs++; $display("FAIL if_rd_ctl got=%b exp=00", {ram_wr_o, if_stall_o}); end
    fin();
    drive(1, 0, 0, 0, 0, 0, 0); half();
    checks++; if ({if_valid_o, if_data_o} !== {1'b1, 8'hA5}) begin errs++; $display("FAIL if_rd_data got=%b/%h exp=1/a5", if_valid_o, if_data_o); end
    fin();
    half();
    checks++; if ({if_valid_o, if_data_o} !== {1'b0, 8'hA5}) begin errs++; $display("FAIL if_rd_hold got=%b/%h exp=0/a5", if_valid_o, if_data_o); end
    checks++; if (ram_addr_o !== 17'h00100) begin errs++; $display("FAIL idle_addr_hold got=%h exp=00100", ram_addr_o); end
    fin();
  endtask

  task automatic test_mem_write();
    drive(1, 0, 0, 1, 1, 32'h0001_F000, 8'h3C); half();
    checks++; if ({ram_wr_o, ram_dout_o, ram_addr_o} !== {1'b1, 8'h3C, 17'h1F000}) begin errs++; $display("FAIL wr_port got=%b/%h/%h exp=1/3c/1f000", ram_wr_o, ram_dout_o, ram_addr_o); end
    fin();
    drive(1, 0, 0, 0, 0, 0, 0); half();
    checks++; if ({mem_valid_o, ram_wr_o} !== 2'b00) begin errs++; $display("FAIL wr_no_valid got=%b exp=00", {mem_valid_o, ram_wr_o}); end
    fin();
    drive(1, 0, 0, 1, 0, 32'hABCD_F000, 0); half(); fin();
    drive(1, 0, 0, 0, 0, 0, 0); half();
    checks++; if ({mem_valid_o, mem_data_o} !== {1'b1, 8'h3C}) begin errs++; $display("FAIL wr_readback got=%b/%h exp=1/3c", mem_valid_o, mem_data_o); end
    fin();
  endtask

  task automatic test_tie();
    drive(1, 1, 32'h0000_0004, 1, 0, 32'h0000_0200, 0); half();
    checks++; if ({ram_addr_o, if_stall_o, mem_stall_o} !== {17'h00200, 1'b1, 1'b0}) begin errs++; $display("FAIL tie_grant got=%h/%b/%b exp=00200/1/0", ram_addr_o, if_stall_o, mem_stall_o); end
    fin();
    drive(1, 1, 32'h0000_0004, 0, 0, 0, 0); half();
    checks++; if ({ram_addr_o, if_stall_o} !== {17'h00004, 1'b0}) begin errs++; $display("FAIL tie_if_next got=%h/%b exp=00004/0", ram_addr_o, if_stall_o); end
    checks++; if ({mem_valid_o, mem_data_o, if_valid_o} !== {1'b1, pat(17'h200), 1'b0}) begin errs++; $display("FAIL tie_mem_rsp got=%b/%h/%b exp=1/%h/0", mem_valid_o, mem_data_o, if_valid_o, pat(17'h200)); end
    fin();
    drive(1, 0, 0, 0, 0, 0, 0); half();
    checks++; if ({if_valid_o, if_data_o, mem_valid_o} !== {1'b1, pat(17'h4), 1'b0}) begin errs++; $display("FAIL tie_if_rsp got=%b/%h/%b exp=1/%h/0", if_valid_o, if_data_o, mem_valid_o, pat(17'h4)); end
    fin();
  endtask

  task automatic test_back_to_back();
    logic [16:0] a;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h0000_0040, 1, 0, 32'h0000_0010 + 32'(i), 0); half();
      a = 17'h10 + 17'(i);
      checks++; if ({ram_addr_o, if_stall_o, if_valid_o} !== {a, 1'b1, 1'b0}) begin errs++; $display("FAIL b2b_grant%0d got=%h/%b/%b exp=%h/1/0", i, ram_addr_o, if_stall_o, if_valid_o, a); end
      if (i > 0) begin
        checks++; if ({mem_valid_o, mem_data_o} !== {1'b1, pat(a - 17'h1)}) begin errs++; $display("FAIL b2b_byte%0d got=%b/%h exp=1/%h", i - 1, mem_valid_o, mem_data_o, pat(a - 17'h1)); end
      end
      fin();
    end
    drive(1, 1, 32'h0000_0040, 0, 0, 0, 0); half();
    checks++; if ({mem_valid_o, mem_data_o, ram_addr_o, if_stall_o} !== {1'b1, pat(17'h13), 17'h00040, 1'b0}) begin errs++; $display("FAIL b2b_last got=%b/%h/%h/%b exp=1/%h/00040/0", mem_valid_o, mem_data_o, ram_addr_o, if_stall_o, pat(17'h13)); end
    fin();
    drive(1, 0, 0, 0, 0, 0, 0); half();
    checks++; if ({if_valid_o, if_data_o} !== {1'b1, pat(17'h40)}) begin errs++; $display("FAIL b2b_if_after got=%b/%h exp=1/%h", if_valid_o, if_data_o, pat(17'h40)); end
    fin();
  endtask

  task automatic test_rdy_low();
    drive(1, 1, 32'h0000_0060, 0, 0, 0, 0); half(); fin();
    drive(1, 1, 32'h0000_0061, 0, 0, 0, 0); half();
    checks++; if ({if_valid_o, if_data_o} !== {1'b1, pat(17'h60)}) begin errs++; $display("FAIL rdy_pre got=%b/%h exp=1/%h", if_valid_o, if_data_o, pat(17'h60)); end
    fin();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h0000_0062, 0, 0, 0, 0); half();
      checks++; if ({ram_wr_o, if_stall_o, ram_addr_o} !== {1'b0, 1'b1, 17'h00061}) begin errs++; $display("FAIL rdy_freeze%0d got=%b/%b/%h exp=0/1/00061", k, ram_wr_o, if_stall_o, ram_addr_o); end
      checks++; if ({if_valid_o, if_data_o} !== {(k == 0), pat(17'h61)}) begin errs++; $display("FAIL rdy_pend%0d got=%b/%h exp=%0d/%h", k, if_valid_o, if_data_o, (k == 0), pat(17'h61)); end
      fin();
    end
    drive(1, 1, 32'h0000_0062, 0, 0, 0, 0); half();
    checks++; if ({ram_addr_o, if_stall_o, if_valid_o} !== {17'h00062, 1'b0, 1'b0}) begin errs++; $display("FAIL rdy_resume got=%h/%b/%b exp=00062/0/0", ram_addr_o, if_stall_o, if_valid_o); end
    fin();
    drive(1, 0, 0, 0, 0, 0, 0); half();
    checks++; if ({if_valid_o, if_data_o} !== {1'b1, pat(17'h62)}) begin errs++; $display("FAIL rdy_resume_rsp got=%b/%h exp=1/%h", if_valid_o, if_data_o, pat(17'h62)); end
    fin();
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 32'h0000_0080, 0, 0, 0, 0); half(); fin();
    rst_n = 1'b0;
    #1;
    checks++; if ({if_valid_o, if_data_o, mem_data_o, ram_addr_o, if_stall_o, ram_wr_o} !== 35'h0) begin errs++; $display("FAIL rstmid_out got=%b/%h/%h/%h/%b/%b exp=all0", if_valid_o, if_data_o, mem_data_o, ram_addr_o, if_stall_o, ram_wr_o); end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      half();
      checks++; if ({if_valid_o, mem_valid_o, if_data_o} !== 10'h0) begin errs++; $display("FAIL rstmid_drop%0d got=%b/%b/%h exp=0/0/00", k, if_valid_o, mem_valid_o, if_data_o); end
      fin();
    end
  endtask

  task automatic test_random();
    logic [31:0] hi;
    logic [16:0] lo;
    int          burst;
    burst = 0;
    for (int c = 0; c < 400; c++) begin
      if (burst == 0 && $urandom_range(0, 99) < 30) burst = $urandom_range(1, 4);
      hi = $urandom();
      lo = ($urandom_range(0, 3) == 0) ? 17'h1F000 + 17'($urandom_range(0, 15)) : 17'($urandom_range(0, 63));
      mem_addr_i = {hi[31:17], lo};
      mem_req_i  = (burst > 0);
      mem_write_enable_i = ($urandom_range(0, 99) < 35);
      mem_data_i = 8'($urandom());
      hi = $urandom();
      lo = 17'($urandom_range(0, 63));
      if_addr_i  = {hi[31:17], lo};
      if_req_i   = ($urandom_range(0, 2) != 0);
      rdy        = ($urandom_range(0, 99) < 85);
      half();
      if (burst > 0 && rdy) burst--;
      checks++; if (ram_addr_o !== e_addr) begin errs++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, ram_addr_o, e_addr); end
      checks++; if ({ram_wr_o, ram_dout_o} !== {e_wr, e_dout}) begin errs++; $display("FAIL rnd_wr c=%0d got=%b/%h exp=%b/%h", c, ram_wr_o, ram_dout_o, e_wr, e_dout); end
      checks++; if ({if_stall_o, mem_stall_o} !== {e_if_stall, e_mem_stall}) begin errs++; $display("FAIL rnd_stall c=%0d got=%b%b exp=%b%b", c, if_stall_o, mem_stall_o, e_if_stall, e_mem_stall); end
      checks++; if ({if_valid_o, if_data_o} !== {e_if_valid, e_if_data}) begin errs++; $display("FAIL rnd_if c=%0d got=%b/%h exp=%b/%h", c, if_valid_o, if_data_o, e_if_valid, e_if_data); end
      checks++; if ({mem_valid_o, mem_data_o} !== {e_mem_valid, e_mem_data}) begin errs++; $display("FAIL rnd_mem c=%0d got=%b/%h exp=%b/%h", c, mem_valid_o, mem_data_o, e_mem_valid, e_mem_data); end
      fin();
    end
    drive(1, 0, 0, 0, 0, 0, 0); half(); fin();
  endtask

`ifdef MEM_CTRL_STAT_EN
  task automatic test_stats();
    half();
    checks++; if (stat_rd_o !== m_st_rd) begin errs++; $display("FAIL stat_rd got=%0d exp=%0d", stat_rd_o, m_st_rd); end
    checks++; if (stat_wr_o !== m_st_wr) begin errs++; $display("FAIL stat_wr got=%0d exp=%0d", stat_wr_o, m_st_wr); end
    checks++; if (stat_conf_o !== m_st_conf) begin errs++; $display("FAIL stat_conf got=%0d exp=%0d", stat_conf_o, m_st_conf); end
    fin();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_if_read();
    test_mem_write();
    test_tie();
    test_back_to_back();
    test_rdy_low();
    test_reset_mid();
    test_random();
`ifdef MEM_CTRL_STAT_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
